serial_input_framer: RTL and testbench

SERIAL_INPUT_FRAMER -- requirements
Module: serial_input_framer

---
 rtl/serial_input_framer_pkg.sv | 18 +
 rtl/serial_shift_counter.sv | 35 +++
 rtl/serial_input_framer.sv | 99 +++++++++
 tb/tb_serial_input_framer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_input_framer_pkg.sv
// Shared definitions for the serial input framer: frame geometry, default timeout
// and the framer FSM state encoding.
package serial_input_framer_pkg;

  localparam int unsigned FRAME_BITS      = 9;
  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 16;
  localparam int unsigned CNT_W           = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCheck,
    StReq,
    StConf
  } state_e;

endpackage

// File: rtl/serial_shift_counter.sv
// 9-bit LSB-first shift register with a received-bit counter; a start loads the
// first bit, later shifts fill from the top so bit 0 ends up at index 0.
module serial_shift_counter
  import serial_input_framer_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_start,
  input  logic                  i_shift,
  input  logic                  i_bit,
  output logic [FRAME_BITS-1:0] o_frame,
  output logic [CNT_W-1:0]      o_count
);

  logic [FRAME_BITS-1:0] r_frame;
  logic [CNT_W-1:0]      r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_frame <= '0;
      r_count <= '0;
    end else if (i_start) begin
      r_frame <= {i_bit, {(FRAME_BITS-1){1'b0}}};
      r_count <= CNT_W'(1);
    end else if (i_shift) begin
      r_frame <= {i_bit, r_frame[FRAME_BITS-1:1]};
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_frame = r_frame;
  assign o_count = r_count;

endmodule

// File: rtl/serial_input_framer.sv
// Assembles 9-bit even-parity serial frames into bytes and hands each good byte
// downstream with a request pulse followed by a confirm pulse.
module serial_input_framer
  import serial_input_framer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serialIn,
  input  logic                 serialValid,
  output logic [DATA_BITS-1:0] inputData,
  output logic                 request,
  output logic                 confirm,
  output logic                 frameError
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

  state_e                r_state, w_state_next;
  logic [GAP_W-1:0]      r_gap;
  logic [GAP_W-1:0]      w_gap_inc;
  logic [FRAME_BITS-1:0] w_frame;
  logic [CNT_W-1:0]      w_count;
  logic                  w_start, w_shift, w_timeout, w_parity_ok;
  logic                  w_load, w_request_d, w_confirm_d, w_frame_error_d;
  logic [DATA_BITS-1:0]  r_input_data;
  logic                  r_request, r_confirm, r_frame_error;

  serial_shift_counter u_shift (
    .i_clock (clock),
    .i_reset (reset),
    .i_clear (w_timeout),
    .i_start (w_start),
    .i_shift (w_shift),
    .i_bit   (serialIn),
    .o_frame (w_frame),
    .o_count (w_count)
  );

  assign w_gap_inc   = r_gap + GAP_W'(1);
  // A strobe in the cycle the gap would expire wins over the timeout.
  assign w_timeout   = (r_state == StShift) && !serialValid && (w_gap_inc == GAP_W'(TIMEOUT));
  assign w_start     = (r_state == StIdle) && serialValid;
  assign w_shift     = (r_state == StShift) && serialValid;
  assign w_parity_ok = ~^w_frame;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_next;
      r_gap   <= (r_state == StShift && !serialValid && !w_timeout) ? w_gap_inc : '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (serialValid) w_state_next = StShift;
      StShift: begin
        if (serialValid && (w_count == CNT_W'(FRAME_BITS - 1))) w_state_next = StCheck;
        else if (w_timeout)                                    w_state_next = StIdle;
      end
      StCheck: w_state_next = w_parity_ok ? StReq : StIdle;
      StReq:   w_state_next = StConf;
      StConf:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_load          = (r_state == StCheck) && w_parity_ok;
    w_request_d     = (w_state_next == StReq);
    w_confirm_d     = (w_state_next == StConf);
    w_frame_error_d = ((r_state == StCheck) && !w_parity_ok) || w_timeout;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_input_data  <= '0;
      r_request     <= 1'b0;
      r_confirm     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      if (w_load) r_input_data <= w_frame[DATA_BITS-1:0];
      r_request     <= w_request_d;
      r_confirm     <= w_confirm_d;
      r_frame_error <= w_frame_error_d;
    end
  end

  assign inputData  = r_input_data;
  assign request    = r_request;
  assign confirm    = r_confirm;
  assign frameError = r_frame_error;

endmodule

// File: tb/tb_serial_input_framer.sv
// Directed bench for serial_input_framer: good frames, parity error, timeout,
// near-timeout gap, reset during confirm and strobes held through the handshake.
module tb_serial_input_framer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serialIn = 1'b0;
  logic       serialValid = 1'b0;
  logic [7:0] inputData;
  logic       request, confirm, frameError;

  int n_tests = 0;
  int n_fail  = 0;

  serial_input_framer #(.TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .serialIn    (serialIn),
    .serialValid (serialValid),
    .inputData   (inputData),
    .request     (request),
    .confirm     (confirm),
    .frameError  (frameError)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serialIn    = b;
    serialValid = 1'b1;
    tick();
    serialValid = 1'b0;
    serialIn    = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    serialValid = 1'b1;
    serialIn = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({request, confirm, frameError} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 000", {request, confirm, frameError});
    end
    n_tests++;
    if (inputData !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 00", inputData);
    end
    serialValid = 1'b0;
    serialIn = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b0);
    n_tests++;
    if ({request, confirm, frameError} !== 3'b000) begin
      n_fail++;
      $display("FAIL good_check_cycle: got %b want 000", {request, confirm, frameError});
    end
    tick();
    n_tests++;
    if ({request, confirm, frameError} !== 3'b100 || inputData !== 8'hA5) begin
      n_fail++;
      $display("FAIL good_request: got rcf=%b data=%h want 100 a5",
               {request, confirm, frameError}, inputData);
    end
    tick();
    n_tests++;
    if ({request, confirm, frameError} !== 3'b010 || inputData !== 8'hA5) begin
      n_fail++;
      $display("FAIL good_confirm: got rcf=%b data=%h want 010 a5",
               {request, confirm, frameError}, inputData);
    end
    tick();
    n_tests++;
    if ({request, confirm, frameError} !== 3'b000) begin
      n_fail++;
      $display("FAIL good_after: got %b want 000", {request, confirm, frameError});
    end
  endtask

  task automatic test_parity_error();
    send_frame(8'h01, 1'b0);
    tick();
    n_tests++;
    if ({request, confirm, frameError} !== 3'b001 || inputData !== 8'hA5) begin
      n_fail++;
      $display("FAIL parity_error: got rcf=%b data=%h want 001 a5",
               {request, confirm, frameError}, inputData);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({request, confirm, frameError} !== 3'b000 || inputData !== 8'hA5) begin
        n_fail++;
        $display("FAIL parity_after[%0d]: got rcf=%b data=%h want 000 a5",
                 i, {request, confirm, frameError}, inputData);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    for (int i = 0; i < 15; i++) tick();
    n_tests++;
    if (frameError !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got %b want 0", frameError);
    end
    tick();
    n_tests++;
    if ({request, confirm, frameError} !== 3'b001 || inputData !== 8'hA5) begin
      n_fail++;
      $display("FAIL timeout_pulse: got rcf=%b data=%h want 001 a5",
               {request, confirm, frameError}, inputData);
    end
    tick();
    n_tests++;
    if (frameError !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_once: got %b want 0", frameError);
    end
    send_frame(8'h3C, 1'b0);
    tick();
    n_tests++;
    if (request !== 1'b1 || inputData !== 8'h3C) begin
      n_fail++;
      $display("FAIL timeout_next_frame: got req=%b data=%h want 1 3c", request, inputData);
    end
    tick();
    tick();
  endtask

  task automatic test_near_timeout_gap();
    int errs = 0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (frameError !== 1'b0) errs++;
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL gap15_no_error: got %0d error cycles want 0", errs);
    end
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_bit(1'b0);
    tick();
    n_tests++;
    if ({request, confirm, frameError} !== 3'b100 || inputData !== 8'hFF) begin
      n_fail++;
      $display("FAIL gap15_frame: got rcf=%b data=%h want 100 ff",
               {request, confirm, frameError}, inputData);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_in_conf();
    send_frame(8'h5A, 1'b0);
    tick();
    tick();
    n_tests++;
    if (confirm !== 1'b1 || inputData !== 8'h5A) begin
      n_fail++;
      $display("FAIL conf_reached: got conf=%b data=%h want 1 5a", confirm, inputData);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if ({request, confirm, frameError} !== 3'b000 || inputData !== 8'h00) begin
      n_fail++;
      $display("FAIL conf_reset: got rcf=%b data=%h want 000 00",
               {request, confirm, frameError}, inputData);
    end
    tick();
    n_tests++;
    if ({request, confirm, frameError} !== 3'b000) begin
      n_fail++;
      $display("FAIL conf_after_release: got %b want 000", {request, confirm, frameError});
    end
    send_frame(8'h81, 1'b0);
    tick();
    n_tests++;
    if (request !== 1'b1 || inputData !== 8'h81) begin
      n_fail++;
      $display("FAIL conf_next_frame: got req=%b data=%h want 1 81", request, inputData);
    end
    tick();
    tick();
  endtask

  task automatic test_held_strobes();
    for (int i = 0; i < 8; i++) send_bit(1'b0 ^ (i < 4));
    // Parity bit, then strobes stay high through CHECK, REQ and CONF.
    serialIn = 1'b0;
    serialValid = 1'b1;
    tick();
    serialIn = 1'b1;
    tick();
    n_tests++;
    if (request !== 1'b1 || inputData !== 8'h0F) begin
      n_fail++;
      $display("FAIL held_request: got req=%b data=%h want 1 0f", request, inputData);
    end
    tick();
    n_tests++;
    if (confirm !== 1'b1) begin
      n_fail++;
      $display("FAIL held_confirm: got %b want 1", confirm);
    end
    tick();
    serialValid = 1'b0;
    serialIn = 1'b0;
    tick();
    send_frame(8'h96, 1'b0);
    tick();
    n_tests++;
    if ({request, confirm, frameError} !== 3'b100 || inputData !== 8'h96) begin
      n_fail++;
      $display("FAIL held_next_frame: got rcf=%b data=%h want 100 96",
               {request, confirm, frameError}, inputData);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_timeout();
    test_near_timeout_gap();
    test_reset_in_conf();
    test_held_strobes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
